// File: rtl/button_mode_ctrl_if.sv
// Raw push-button inputs and conditioned mode/button outputs
// for the clock front end.
interface button_mode_ctrl_if;
    logic       btn_mode_raw;
    logic       btn1_raw;
    logic       btn2_raw;
    logic       btn3_raw;
    logic [1:0] clk_mode;
    logic       button1;
    logic       button2;
    logic       button3;
    logic       mode_chg;

    modport master (
        output btn_mode_raw,
        output btn1_raw,
        output btn2_raw,
        output btn3_raw,
        input  clk_mode,
        input  button1,
        input  button2,
        input  button3,
        input  mode_chg
    );

    modport slave (
        input  btn_mode_raw,
        input  btn1_raw,
        input  btn2_raw,
        input  btn3_raw,
        output clk_mode,
        output button1,
        output button2,
        output button3,
        output mode_chg
    );
endinterface

// File: rtl/button_mode_ctrl.sv
// Button conditioning (sync, debounce, press pulse, auto-repeat)
// and the clock-mode FSM with idle timeout.
module button_mode_ctrl #(
    parameter int unsigned DB_CYCLES    = 50000,
    parameter int unsigned RPT_DELAY    = 500000,
    parameter int unsigned RPT_PERIOD   = 150000,
    parameter int unsigned IDLE_TIMEOUT = 8000000
) (
    input  logic               clk,
    input  logic               rst_n,
    button_mode_ctrl_if.slave  bus
);

    localparam int unsigned RPT_MAX =
        (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(RPT_PERIOD - 1);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_TIME = 2'b01,
        ALARM    = 2'b10,
        SET_DATE = 2'b11
    } mode_e;

    // bit 0 = mode button, bits 1..3 = btn1..btn3
    logic [3:0] w_raw;
    logic [3:0] w_pulse;

    assign w_raw = {bus.btn3_raw, bus.btn2_raw,
                    bus.btn1_raw, bus.btn_mode_raw};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic            r_s1;
        logic            r_s2;
        logic            r_lvl;
        logic            r_lvl_q;
        logic            r_pulse;
        logic [DB_W-1:0] r_db_cnt;
        logic            w_rise;
        logic            w_rep;

        assign w_rise = r_lvl & ~r_lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_lvl    <= 1'b0;
                r_lvl_q  <= 1'b0;
                r_pulse  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_s1    <= w_raw[gi];
                r_s2    <= r_s1;
                r_lvl_q <= r_lvl;
                r_pulse <= w_rise | w_rep;
                if (r_s2 == r_lvl) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_lvl    <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        if (gi == 1 || gi == 2) begin : g_rpt
            logic [RPT_W-1:0] r_hold_cnt;
            logic             r_first;
            logic [RPT_W-1:0] w_target;

            // first gap is the long delay, later gaps the period
            assign w_target = r_first ? RD_LAST : RP_LAST;
            assign w_rep    = r_lvl & ~w_rise &
                              (r_hold_cnt == w_target);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold_cnt <= '0;
                    r_first    <= 1'b1;
                end else if (!r_lvl || w_rise) begin
                    r_hold_cnt <= '0;
                    r_first    <= 1'b1;
                end else if (w_rep) begin
                    r_hold_cnt <= '0;
                    r_first    <= 1'b0;
                end else if (r_hold_cnt != '1) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end else begin : g_norpt
            assign w_rep = 1'b0;
        end

        assign w_pulse[gi] = r_pulse;
    end

    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic             r_mode_chg;
    logic             w_chg_nxt;
    logic [IDL_W-1:0] r_idle;
    logic [IDL_W-1:0] w_idle_nxt;
    logic             w_btn_en;
    logic             w_b1;
    logic             w_b2;
    logic             w_b3;
    logic             w_idle_clr;

    // a mode press in the same cycle swallows any button pulse
    assign w_btn_en = (r_mode != RUN) & ~r_mode_chg & ~w_pulse[0];
    assign w_b1     = w_pulse[1] & w_btn_en;
    assign w_b2     = w_pulse[2] & w_btn_en;
    assign w_b3     = w_pulse[3] & w_btn_en;

    assign w_idle_clr = w_pulse[0] | w_b1 | w_b2 | w_b3 | r_mode_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= RUN;
            r_mode_chg <= 1'b0;
            r_idle     <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_mode_chg <= w_chg_nxt;
            r_idle     <= w_idle_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_chg_nxt  = 1'b0;
        w_idle_nxt = r_idle;
        if (w_pulse[0]) begin
            w_chg_nxt  = 1'b1;
            w_idle_nxt = '0;
            unique case (r_mode)
                RUN:      w_mode_nxt = SET_TIME;
                SET_TIME: w_mode_nxt = ALARM;
                ALARM:    w_mode_nxt = SET_DATE;
                SET_DATE: w_mode_nxt = RUN;
            endcase
        end else if (r_mode == RUN || w_idle_clr) begin
            w_idle_nxt = '0;
        end else if (r_idle == IDL_LAST) begin
            w_mode_nxt = RUN;
            w_chg_nxt  = 1'b1;
            w_idle_nxt = '0;
        end else begin
            w_idle_nxt = r_idle + 1'b1;
        end
    end

    assign bus.clk_mode = r_mode;
    assign bus.mode_chg = r_mode_chg;
    assign bus.button1  = w_b1;
    assign bus.button2  = w_b2;
    assign bus.button3  = w_b3;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Scoreboard bench for button_mode_ctrl with short debounce,
// repeat and timeout parameters.
module tb_button_mode_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_mode_ctrl_if bus();

    button_mode_ctrl #(
        .DB_CYCLES   (4),
        .RPT_DELAY   (20),
        .RPT_PERIOD  (5),
        .IDLE_TIMEOUT(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [1:0] m;
    } evt_t;

    localparam logic [3:0] B1  = 4'b0001;
    localparam logic [3:0] B2  = 4'b0010;
    localparam logic [3:0] B3  = 4'b0100;
    localparam logic [3:0] CHG = 4'b1000;

    evt_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] p,
                        input logic [1:0] m);
        evt_t e;
        e.cyc = c;
        e.p   = p;
        e.m   = m;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mode_press(input logic [1:0] nm);
        int n;
        n = cyc;
        push(n + 8, CHG, nm);
        bus.btn_mode_raw = 1'b1;
        tick(8);
        bus.btn_mode_raw = 1'b0;
        tick(4);
    endtask

    task automatic chk_idle_outs(input string nm, input int md);
        chk({nm, "_mode"}, int'(bus.clk_mode), md);
        chk({nm, "_b1"},   int'(bus.button1), 0);
        chk({nm, "_b2"},   int'(bus.button2), 0);
        chk({nm, "_b3"},   int'(bus.button3), 0);
        chk({nm, "_chg"},  int'(bus.mode_chg), 0);
    endtask

    initial begin : mon
        logic [3:0] p;
        evt_t       e;
        forever begin
            @(posedge clk);
            #1;
            p = {bus.mode_chg, bus.button3, bus.button2, bus.button1};
            if (rst_n && p != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'(p), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_cyc",   cyc, e.cyc);
                    chk("evt_pulse", int'(p), int'(e.p));
                    chk("evt_mode",  int'(bus.clk_mode), int'(e.m));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int   n;
        int   q;
        int   t;
        int   w;
        evt_t e;

        bus.btn_mode_raw = 1'b0;
        bus.btn1_raw     = 1'b0;
        bus.btn2_raw     = 1'b0;
        bus.btn3_raw     = 1'b0;
        tick(3);
        chk_idle_outs("reset", 0);
        rst_n = 1'b1;
        tick(2);

        // btn3 in RUN: masked
        bus.btn3_raw = 1'b1;
        tick(8);
        bus.btn3_raw = 1'b0;
        tick(10);

        // into SET_TIME
        n = cyc;
        push(n + 8, CHG, 2'b01);
        bus.btn_mode_raw = 1'b1;
        tick(8);
        bus.btn_mode_raw = 1'b0;

        // 3-cycle glitch on btn1: rejected
        bus.btn1_raw = 1'b1;
        tick(3);
        bus.btn1_raw = 1'b0;
        tick(9);

        // btn1 held 10: single pulse 7 cycles after the edge
        n = cyc;
        push(n + 7, B1, 2'b01);
        bus.btn1_raw = 1'b1;
        tick(10);
        bus.btn1_raw = 1'b0;
        tick(10);

        // into ALARM, btn3 at ~30, then idle timeout
        q = cyc;
        push(q + 8, CHG, 2'b10);
        bus.btn_mode_raw = 1'b1;
        tick(8);
        bus.btn_mode_raw = 1'b0;
        tick(24);
        push(q + 39, B3, 2'b10);
        push(q + 90, CHG, 2'b00);
        bus.btn3_raw = 1'b1;
        tick(8);
        bus.btn3_raw = 1'b0;
        tick(q + 95 - cyc);

        // full mode walk to SET_DATE
        mode_press(2'b01);
        mode_press(2'b10);
        mode_press(2'b11);

        // btn2 held 40: press + 4 repeats
        t = cyc;
        push(t + 7,  B2, 2'b11);
        push(t + 27, B2, 2'b11);
        push(t + 32, B2, 2'b11);
        push(t + 37, B2, 2'b11);
        push(t + 42, B2, 2'b11);
        bus.btn2_raw = 1'b1;
        tick(40);
        bus.btn2_raw = 1'b0;
        tick(10);

        mode_press(2'b00);

        // btn3 in RUN again
        bus.btn3_raw = 1'b1;
        tick(8);
        bus.btn3_raw = 1'b0;
        tick(10);

        // mode and btn1 together: mode wins
        mode_press(2'b01);
        n = cyc;
        push(n + 8, CHG, 2'b10);
        bus.btn_mode_raw = 1'b1;
        bus.btn1_raw     = 1'b1;
        tick(10);
        bus.btn_mode_raw = 1'b0;
        bus.btn1_raw     = 1'b0;
        tick(10);

        // reset while btn1 is held in ALARM
        w = cyc;
        push(w + 7, B1, 2'b10);
        bus.btn1_raw = 1'b1;
        tick(12);
        chk("pre_rst_mode", int'(bus.clk_mode), 2);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("midhold_rst", 0);
        tick(3);
        rst_n = 1'b1;
        tick(12);
        bus.btn1_raw = 1'b0;
        tick(10);
        chk("post_rst_mode", int'(bus.clk_mode), 0);

        tick(5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_evt", -1, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
